// File: rtl/operand_router.sv
// Sequential operand routing stage: accepts one decoded instruction, drives register
// read selects, builds ALU operands, runs the ALU handshake and issues write-back.
module operand_router #(
  parameter int w       = 8,
  parameter int sel_w   = 4,
  parameter int timeout = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [w-1:0]     i1,
  input  logic [w-1:0]     i2,
  input  logic [w-1:0]     i3,
  output logic [sel_w-1:0] x_sel,
  output logic [sel_w-1:0] y_sel,
  input  logic [w-1:0]     x,
  input  logic [w-1:0]     y,
  output logic [w-1:0]     a,
  output logic [w-1:0]     b,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic [w-1:0]     result,
  output logic [w-1:0]     z,
  output logic [sel_w-1:0] z_sel,
  output logic             z_we,
  output logic             err
);

  localparam int cnt_w = $clog2(timeout + 1);
  localparam logic [cnt_w-1:0] timeout_c = cnt_w'(timeout);

  typedef enum logic [2:0] {IDLE, READ, LATCH, START, WAIT, WRITE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [w-1:0]     i1_q, i1_d;
  logic [w-1:0]     i2_q, i2_d;
  logic [sel_w-1:0] i3_q, i3_d;
  logic [sel_w-1:0] x_sel_q, x_sel_d;
  logic [sel_w-1:0] y_sel_q, y_sel_d;
  logic [w-1:0]     a_q, a_d;
  logic [w-1:0]     b_q, b_d;
  logic [w-1:0]     z_q, z_d;
  logic [sel_w-1:0] z_sel_q, z_sel_d;
  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;

  // Only the select-sized low bits of the destination field are meaningful.
  logic unused_i3_hi;
  assign unused_i3_hi = ^i3[w-1:sel_w];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= '0;
      i1_q    <= '0;
      i2_q    <= '0;
      i3_q    <= '0;
      x_sel_q <= '0;
      y_sel_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
      z_sel_q <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      i1_q    <= i1_d;
      i2_q    <= i2_d;
      i3_q    <= i3_d;
      x_sel_q <= x_sel_d;
      y_sel_q <= y_sel_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z_q     <= z_d;
      z_sel_q <= z_sel_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    i1_d    = i1_q;
    i2_d    = i2_q;
    i3_d    = i3_q;
    x_sel_d = x_sel_q;
    y_sel_d = y_sel_q;
    a_d     = a_q;
    b_d     = b_q;
    z_d     = z_q;
    z_sel_d = z_sel_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mode_d  = mode;
          i1_d    = i1;
          i2_d    = i2;
          i3_d    = i3[sel_w-1:0];
          // Selects go out at accept so register data arrives during LATCH.
          x_sel_d = i1[sel_w-1:0];
          y_sel_d = i2[sel_w-1:0];
          state_d = READ;
        end
      end
      READ: state_d = LATCH;
      LATCH: begin
        unique case (mode_q)
          2'b01: begin
            a_d = x;
            b_d = i2_q;
          end
          2'b10: begin
            a_d = i1_q;
            b_d = '0;
          end
          default: begin
            a_d = x;
            b_d = y;
          end
        endcase
        cnt_d   = cnt_w'(1);
        state_d = START;
      end
      START, WAIT: begin
        // A done arriving on the final counted cycle still wins over the abort.
        if (alu_done) begin
          if (mode_q != 2'b11) begin
            z_d     = result;
            z_sel_d = i3_q;
            state_d = WRITE;
          end else begin
            state_d = IDLE;
          end
        end else if (cnt_q == timeout_c) begin
          abort_d = 1'b1;
          state_d = WRITE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = WAIT;
        end
      end
      WRITE: begin
        abort_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The WRITE cycle doubles as the abort cycle, distinguished by abort_q.
  always_comb begin
    in_ready  = (state_q == IDLE) && !reset;
    alu_start = (state_q == START);
    z_we      = (state_q == WRITE) && !abort_q;
    err       = (state_q == WRITE) && abort_q;
    x_sel     = x_sel_q;
    y_sel     = y_sel_q;
    a         = a_q;
    b         = b_q;
    z         = z_q;
    z_sel     = z_sel_q;
  end

endmodule

// File: tb/tb_operand_router.sv
// Self-checking bench for operand_router: directed test-plan cases followed by
// randomized instructions, compared against a spec-level model of each transaction.
module tb_operand_router;

  localparam int TO = 4;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] mode;
  logic [7:0] i1, i2, i3;
  logic [3:0] x_sel, y_sel;
  logic [7:0] x, y;
  logic [7:0] a, b;
  logic       alu_start;
  logic       alu_done;
  logic [7:0] result;
  logic [7:0] z;
  logic [3:0] z_sel;
  logic       z_we;
  logic       err;

  logic [7:0] rf [16];
  int check_count;
  int pass_count;
  int fail_count;

  operand_router #(.w(8), .sel_w(4), .timeout(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .i1(i1), .i2(i2), .i3(i3),
    .x_sel(x_sel), .y_sel(y_sel), .x(x), .y(y),
    .a(a), .b(b), .alu_start(alu_start), .alu_done(alu_done), .result(result),
    .z(z), .z_sel(z_sel), .z_we(z_we), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: read data appears one cycle after the select.
  always @(posedge clk) begin
    x <= rf[x_sel];
    y <= rf[y_sel];
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One full transaction starting in an idle cycle; delay = cycles after START
  // until alu_done, never = ALU never completes.
  task automatic applyStimulus(input logic [1:0] m, input logic [7:0] arg1,
                               input logic [7:0] arg2, input logic [7:0] arg3,
                               input int delay, input bit never, input bit hold);
    logic [7:0] ea, eb, ez;
    logic [3:0] exs, eys, ezs;
    exs = arg1[3:0];
    eys = arg2[3:0];
    ezs = arg3[3:0];
    ea  = (m == 2'd2) ? arg1 : rf[exs];
    case (m)
      2'd1:    eb = arg2;
      2'd2:    eb = 8'h00;
      default: eb = rf[eys];
    endcase
    ez = ea + eb;

    in_valid = 1'b1;
    mode = m;
    i1 = arg1;
    i2 = arg2;
    i3 = arg3;
    checkOutput("accept_ready", in_ready, 1);
    step();
    if (!hold) in_valid = 1'b0;
    checkOutput("read_busy", in_ready, 0);
    checkOutput("x_sel", x_sel, exs);
    checkOutput("y_sel", y_sel, eys);
    step();
    checkOutput("latch_no_start", alu_start, 0);
    step();
    checkOutput("start_pulse", alu_start, 1);
    checkOutput("operand_a", a, ea);
    checkOutput("operand_b", b, eb);
    checkOutput("x_sel_held", x_sel, exs);
    for (int k = 0; k < TO; k++) begin
      if (k > 0) begin
        step();
        checkOutput("start_once", alu_start, 0);
        checkOutput("a_stable", a, ea);
      end
      checkOutput("busy_no_we", z_we, 0);
      checkOutput("busy_no_err", err, 0);
      checkOutput("busy_not_ready", in_ready, 0);
      result = a + b;
      if (!never && k == delay) begin
        alu_done = 1'b1;
        break;
      end
    end
    step();
    alu_done = 1'b0;
    result = 8'h00;
    if (never) begin
      checkOutput("timeout_err", err, 1);
      checkOutput("timeout_no_we", z_we, 0);
      checkOutput("timeout_not_ready", in_ready, 0);
      step();
      checkOutput("after_err_low", err, 0);
      checkOutput("after_err_ready", in_ready, 1);
    end else if (m == 2'd3) begin
      checkOutput("cmp_no_we", z_we, 0);
      checkOutput("cmp_no_err", err, 0);
      checkOutput("cmp_ready", in_ready, 1);
    end else begin
      checkOutput("write_we", z_we, 1);
      checkOutput("write_z", z, ez);
      checkOutput("write_z_sel", z_sel, ezs);
      checkOutput("write_no_err", err, 0);
      checkOutput("write_not_ready", in_ready, 0);
      step();
      checkOutput("we_single", z_we, 0);
      checkOutput("ready_back", in_ready, 1);
      checkOutput("z_hold", z, ez);
    end
  endtask

  initial begin
    check_count = 0;
    pass_count  = 0;
    fail_count  = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    mode     = 2'd0;
    i1 = 8'h00;
    i2 = 8'h00;
    i3 = 8'h00;
    alu_done = 1'b0;
    result   = 8'h00;
    for (int i = 0; i < 16; i++) rf[i] = 8'($urandom);
    rf[2] = 8'h10;
    rf[3] = 8'h12;
    rf[5] = 8'h34;

    step();
    step();
    checkOutput("rst_ready", in_ready, 0);
    checkOutput("rst_a", a, 0);
    checkOutput("rst_b", b, 0);
    checkOutput("rst_z", z, 0);
    checkOutput("rst_x_sel", x_sel, 0);
    checkOutput("rst_y_sel", y_sel, 0);
    checkOutput("rst_z_sel", z_sel, 0);
    checkOutput("rst_start", alu_start, 0);
    checkOutput("rst_we", z_we, 0);
    checkOutput("rst_err", err, 0);
    reset = 1'b0;
    step();
    checkOutput("post_rst_ready", in_ready, 1);

    $display("[TB] directed test-plan cases");
    applyStimulus(2'd0, 8'd3, 8'd5, 8'd7, 0, 1'b0, 1'b0);
    applyStimulus(2'd1, 8'd2, 8'h05, 8'd1, 3, 1'b0, 1'b0);
    applyStimulus(2'd2, 8'hA5, 8'h00, 8'd4, 0, 1'b0, 1'b0);
    applyStimulus(2'd3, 8'd3, 8'd5, 8'd9, 0, 1'b0, 1'b0);
    applyStimulus(2'd0, 8'd3, 8'd5, 8'd7, 0, 1'b1, 1'b0);
    applyStimulus(2'd1, 8'd2, 8'h77, 8'd6, TO - 1, 1'b0, 1'b0);
    applyStimulus(2'd3, 8'd5, 8'd3, 8'd0, 2, 1'b0, 1'b0);

    $display("[TB] reset during WAIT and spurious alu_done");
    in_valid = 1'b1;
    mode = 2'd0;
    i1 = 8'd1;
    i2 = 8'd2;
    i3 = 8'd3;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    step();
    reset = 1'b1;
    step();
    checkOutput("midrst_ready", in_ready, 0);
    checkOutput("midrst_a", a, 0);
    checkOutput("midrst_b", b, 0);
    checkOutput("midrst_z", z, 0);
    checkOutput("midrst_x_sel", x_sel, 0);
    checkOutput("midrst_y_sel", y_sel, 0);
    checkOutput("midrst_z_sel", z_sel, 0);
    checkOutput("midrst_start", alu_start, 0);
    checkOutput("midrst_we", z_we, 0);
    checkOutput("midrst_err", err, 0);
    reset = 1'b0;
    step();
    checkOutput("midrst_ready_back", in_ready, 1);
    alu_done = 1'b1;
    for (int k = 0; k < TO + 2; k++) begin
      step();
      checkOutput("spurious_ready", in_ready, 1);
      checkOutput("spurious_we", z_we, 0);
      checkOutput("spurious_err", err, 0);
      checkOutput("spurious_start", alu_start, 0);
    end
    alu_done = 1'b0;

    $display("[TB] in_valid held high across instructions");
    applyStimulus(2'd0, 8'($urandom), 8'($urandom), 8'($urandom), 0, 1'b0, 1'b1);
    applyStimulus(2'd1, 8'($urandom), 8'($urandom), 8'($urandom), 1, 1'b0, 1'b1);
    applyStimulus(2'd3, 8'($urandom), 8'($urandom), 8'($urandom), 0, 1'b0, 1'b1);
    applyStimulus(2'd2, 8'($urandom), 8'($urandom), 8'($urandom), 2, 1'b0, 1'b0);

    $display("[TB] randomized instructions");
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 16; i++) rf[i] = 8'($urandom);
      applyStimulus(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, TO - 1)), ($urandom_range(0, 7) == 0), 1'b0);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/operand_router.md
# operand_router

Sequential operand routing stage for the datapath: accepts one decoded instruction (mode plus three argument fields), drives register-file read selects, builds the ALU operands from register data or immediates, starts the ALU, waits for completion and issues the register write-back. It sits between the instruction decoder and the register file / ALU. It generalises the earlier combinational router with parametrised widths, four addressing modes, a valid/ready handshake, a multi-cycle ALU handshake and a completion timeout.

## Interface
- `w`, 8, data width of operands, immediates, ALU result and write data
- `sel_w`, 4, register select width; selects are the low `sel_w` bits of the argument fields
- `timeout`, 16, maximum cycles spent waiting for `alu_done` before abort (≥1)
- `clk`  in  1  single clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high
- `in_valid`  in  1  instruction offered
- `in_ready`  out  1  router can accept an instruction
- `mode`  in  2  00 reg-reg, 01 reg-imm, 10 imm-load, 11 reg-reg compare (no write-back)
- `i1`, `i2`, `i3`  in  w each  instruction arguments
- `x_sel`, `y_sel`  out  sel_w each  register-file read selects
- `x`, `y`  in  w each  register-file read data, one cycle after select
- `a`, `b`  out  w each  ALU operands
- `alu_start`  out  1  one-cycle ALU start pulse
- `alu_done`  in  1  ALU result valid
- `result`  in  w  ALU result
- `z`  out  w  write-back data
- `z_sel`  out  sel_w  write-back register select
- `z_we`  out  1  write-back enable, one-cycle pulse
- `err`  out  1  one-cycle pulse on timeout abort

## Operation
- States: IDLE, READ, LATCH, START, WAIT, WRITE.
- IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, capture `mode`, `i1`, `i2`, `i3`; go READ.
- READ: `x_sel`=i1[sel_w-1:0], `y_sel`=i2[sel_w-1:0] (registered, held until next accept); go LATCH.
- LATCH: load `a`/`b` at end of cycle: mode 00/11 a=x, b=y; mode 01 a=x, b=i2; mode 10 a=i1, b=0. Go START.
- START: `alu_start`=1; `a`,`b` stable from START until the next LATCH. Go WAIT, or directly to the done path if `alu_done` is already high.
- WAIT: count cycles from START (START counts as cycle 1). `alu_done` sampled in START and WAIT; on done capture `result` into `z`, `z_sel`=i3[sel_w-1:0]; go WRITE (modes 00/01/10) or IDLE (mode 11, no write). If counter reaches `timeout` without done: pulse `err`, no write, go IDLE.
- WRITE: `z_we`=1 for exactly this cycle; go IDLE.
- `alu_done` outside START/WAIT is ignored.
- `in_ready` is 0 in every state but IDLE; instructions never queued.
- `z`, `z_sel` hold last written values until next capture.

## Timing
- Reset (synchronous, any state): state←IDLE; `a`, `b`, `z`, `x_sel`, `y_sel`, `z_sel`, counter ←0; `alu_start`, `z_we`, `err` ←0. `in_ready`=0 while `reset` high, 1 the first cycle after.
- Reset mid-operation abandons the instruction: no `z_we`, no `err`, no `alu_start` afterwards.
- Accept at edge N: READ N+1, LATCH N+2, START N+3 (`alu_start` high), done in N+3 → WRITE N+4 (`z_we` high), `in_ready` high N+5. Minimum issue interval 5 cycles (4 for mode 11).
- Each extra cycle `alu_done` is late adds one cycle.
- Timeout: `alu_done` never asserted → `err` high in cycle N+3+`timeout`, `in_ready` high the cycle after.
- `alu_done` in the same cycle the counter reaches `timeout`: done wins, no `err`.
- Selects and immediates truncate to `sel_w`/`w`; no arithmetic is performed in the router.

## Test plan
- Reset then mode 00, i1=3, i2=5, i3=7, register file R3=0x12, R5=0x34, ALU adds with done in START → `x_sel`=3, `y_sel`=5, a=0x12, b=0x34, `z`=0x46, `z_sel`=7, `z_we` single pulse at N+4, `in_ready` back at N+5.
- Mode 01 i1=2 (R2=0x10), i2=0x05, i3=1, ALU done 3 cycles after start → b=0x05, `z_we` at N+7, no `err`.
- Mode 10 i1=0xA5, i3=4, ALU passes a → a=0xA5, b=0, `z`=0xA5, `z_sel`=4. Mode 11 → no `z_we`, `in_ready` back at N+4.
- `timeout`=4, `alu_done` held low → `err` pulse at N+7, no `z_we`, next instruction accepted at N+8; repeat with done exactly at counter=4 → write, no `err`.
- Reset asserted in WAIT → all outputs 0 next cycle, no `z_we`/`err`; spurious `alu_done` in IDLE → ignored; `in_valid` held high continuously → one accept per completion only.
